// File: rtl/decode.sv
// RV32I instruction-decode stage: IF/ID capture with wrong-path filtering,
// field/immediate decode into an ID/EX register, and early JAL redirect.
module decode #(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] final_pc,
    input  logic [31:0] final_inst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] b_target,
    output logic        jal_req,
    output logic [31:0] jal_target,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        use_imm,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [0:0] {NORMAL = 1'b0, REDIRECT = 1'b1} filt_state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        use_imm;
        logic        is_lui;
        logic        is_auipc;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_j_f(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic dec_t decode_f(input logic [31:0] inst);
        dec_t        d;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'h000};
        d = '0;
        case (inst[6:0])
            OPC_LUI:    begin d.rd = inst[11:7]; d.imm = imm_u; d.reg_we = 1'b1; d.use_imm = 1'b1; d.is_lui = 1'b1; end
            OPC_AUIPC:  begin d.rd = inst[11:7]; d.imm = imm_u; d.reg_we = 1'b1; d.use_imm = 1'b1; d.is_auipc = 1'b1; end
            OPC_JAL:    begin d.rd = inst[11:7]; d.imm = imm_j_f(inst); d.reg_we = 1'b1; d.is_jal = 1'b1; end
            OPC_JALR:   begin d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i; d.reg_we = 1'b1; d.use_imm = 1'b1; d.is_jalr = 1'b1; end
            OPC_BRANCH: begin d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_b; d.is_branch = 1'b1; end
            OPC_LOAD:   begin d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i; d.reg_we = 1'b1; d.mem_re = 1'b1; d.use_imm = 1'b1; end
            OPC_STORE:  begin d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_s; d.mem_we = 1'b1; d.use_imm = 1'b1; end
            OPC_OPIMM: begin
                d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i; d.reg_we = 1'b1; d.use_imm = 1'b1;
                d.alu_op = {inst[30] & (inst[14:12] == 3'b101), inst[14:12]};
            end
            OPC_OP: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.rd = inst[11:7]; d.reg_we = 1'b1;
                d.alu_op = {inst[30], inst[14:12]};
            end
            // Fence and system instructions keep their I-format fields but drive no control
            OPC_MISC, OPC_SYSTEM: begin d.rs1 = inst[19:15]; d.rd = inst[11:7]; d.imm = imm_i; end
            default: d.illegal = 1'b1;
        endcase
        d.reg_we = d.reg_we & (d.rd != 5'd0);
        return d;
    endfunction

    filt_state_t state_r;
    logic [31:0] exp_pc_r;
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_inst_r;
    logic        jal_sent_r;
    logic        id_valid_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    dec_t        id_dec_r;

    logic        real_s;
    logic [31:0] jal_sum_s;
    logic        jal_req_s;
    logic        filtering_s;
    logic [31:0] cmp_pc_s;
    logic        accept_s;
    dec_t        if_dec_s;

    // JAL detection, wrong-path filter decision and decode of the IF/ID entry
    always_comb begin
        real_s    = (final_inst != NOP);
        jal_sum_s = if_pc_r + imm_j_f(if_inst_r);
        jal_req_s = if_valid_r & (if_inst_r[6:0] == OPC_JAL) & ~jal_sent_r & ~flush;
        if (jal_req_s) begin
            filtering_s = 1'b1;
            cmp_pc_s    = jal_sum_s;
        end else begin
            filtering_s = (state_r == REDIRECT);
            cmp_pc_s    = exp_pc_r;
        end
        accept_s = real_s & (~filtering_s | (final_pc == cmp_pc_s));
        if (if_valid_r) begin
            if_dec_s = decode_f(if_inst_r);
        end else begin
            if_dec_s = '0;
        end
    end

    // Pipeline registers and filter state; priority rst > flush > stall > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= NORMAL;
            exp_pc_r   <= 32'h0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0;
            if_inst_r  <= 32'h0;
            jal_sent_r <= 1'b0;
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0;
            id_inst_r  <= NOP;
            id_dec_r   <= '0;
        end else if (flush) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0;
            id_inst_r  <= NOP;
            id_dec_r   <= '0;
            jal_sent_r <= 1'b0;
            exp_pc_r   <= b_target;
            if (real_s && (final_pc == b_target)) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= final_pc;
                if_inst_r  <= final_inst;
                state_r    <= NORMAL;
            end else begin
                if_valid_r <= 1'b0;
                state_r    <= REDIRECT;
            end
        end else if (stall) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0;
            id_inst_r  <= NOP;
            id_dec_r   <= '0;
            // A held JAL requests its redirect once; jal_sent blocks repeats
            if (jal_req_s) begin
                jal_sent_r <= 1'b1;
                state_r    <= REDIRECT;
                exp_pc_r   <= jal_sum_s;
            end
        end else begin
            id_valid_r <= if_valid_r;
            id_pc_r    <= if_valid_r ? if_pc_r : 32'h0;
            id_inst_r  <= if_valid_r ? if_inst_r : NOP;
            id_dec_r   <= if_dec_s;
            jal_sent_r <= 1'b0;
            if (jal_req_s) begin
                exp_pc_r <= jal_sum_s;
            end
            if (accept_s) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= final_pc;
                if_inst_r  <= final_inst;
                state_r    <= NORMAL;
            end else begin
                if_valid_r <= 1'b0;
                if (jal_req_s) begin
                    state_r <= REDIRECT;
                end
            end
        end
    end

    assign jal_req    = jal_req_s;
    assign jal_target = jal_req_s ? jal_sum_s : 32'h0;
    assign id_valid   = id_valid_r;
    assign id_pc      = id_pc_r;
    assign id_inst    = id_inst_r;
    assign rs1        = id_dec_r.rs1;
    assign rs2        = id_dec_r.rs2;
    assign rd         = id_dec_r.rd;
    assign imm        = id_dec_r.imm;
    assign alu_op     = id_dec_r.alu_op;
    assign reg_we     = id_dec_r.reg_we;
    assign mem_re     = id_dec_r.mem_re;
    assign mem_we     = id_dec_r.mem_we;
    assign is_branch  = id_dec_r.is_branch;
    assign is_jal     = id_dec_r.is_jal;
    assign is_jalr    = id_dec_r.is_jalr;
    assign use_imm    = id_dec_r.use_imm;
    assign is_lui     = id_dec_r.is_lui;
    assign is_auipc   = id_dec_r.is_auipc;
    assign illegal    = id_dec_r.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios plus randomized traffic, every cycle
// compared against a format-table reference decoder and a slot-level filter model.
module tb_decode;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [6:0]  JALO = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] final_pc;
    logic [31:0] final_inst;
    logic        stall;
    logic        flush;
    logic [31:0] b_target;
    logic        jal_req;
    logic [31:0] jal_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, use_imm, is_lui, is_auipc, illegal;

    always #5 clk = ~clk;

    decode #(.NOP(NOP)) dut (
        .clk(clk), .rst(rst), .final_pc(final_pc), .final_inst(final_inst),
        .stall(stall), .flush(flush), .b_target(b_target),
        .jal_req(jal_req), .jal_target(jal_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .use_imm(use_imm), .is_lui(is_lui),
        .is_auipc(is_auipc), .illegal(illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, use_imm, is_lui, is_auipc, illegal;
    } pkt_t;

    pkt_t obs;
    assign obs = {id_valid, id_pc, id_inst, rs1, rs2, rd, imm, alu_op,
                  reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, use_imm, is_lui, is_auipc, illegal};

    int checks = 0;
    int errors = 0;
    int jal_pulses = 0;
    logic chk_en = 1'b0;

    // Slot-level model: one IF/ID slot, a "waiting for PC" flag and a pulse-sent flag
    logic        m_valid, m_sent, m_wait;
    logic [31:0] m_pc, m_inst, m_want;
    pkt_t        exp_pkt;

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference decoder: classify format first, then pull fields by format
    function automatic pkt_t ref_dec(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        pkt_t p;
        byte fmt;
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] sx;
        logic wr;
        p = '0;
        p.inst = NOP;
        if (!v) return p;
        p.valid = 1'b1; p.pc = pc; p.inst = inst;
        op = inst[6:0]; f3 = inst[14:12];
        sx = inst[31] ? 32'hFFFF_FFFF : 32'h0;
        wr = 1'b0;
        case (op)
            7'b0110011: fmt = "R";
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = "I";
            7'b0100011: fmt = "S";
            7'b1100011: fmt = "B";
            7'b0110111, 7'b0010111: fmt = "U";
            7'b1101111: fmt = "J";
            default: fmt = "X";
        endcase
        if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") p.rs1 = inst[19:15];
        if (fmt == "R" || fmt == "S" || fmt == "B") p.rs2 = inst[24:20];
        if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") p.rd = inst[11:7];
        case (fmt)
            "I": p.imm = (sx << 12) | 32'(inst[31:20]);
            "S": p.imm = (sx << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
            "B": p.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            "U": p.imm = inst & 32'hFFFF_F000;
            "J": p.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            default: p.imm = 32'h0;
        endcase
        case (op)
            7'b0110111: begin wr = 1'b1; p.use_imm = 1'b1; p.is_lui = 1'b1; end
            7'b0010111: begin wr = 1'b1; p.use_imm = 1'b1; p.is_auipc = 1'b1; end
            7'b1101111: begin wr = 1'b1; p.is_jal = 1'b1; end
            7'b1100111: begin wr = 1'b1; p.use_imm = 1'b1; p.is_jalr = 1'b1; end
            7'b1100011: p.is_branch = 1'b1;
            7'b0000011: begin wr = 1'b1; p.mem_re = 1'b1; p.use_imm = 1'b1; end
            7'b0100011: begin p.mem_we = 1'b1; p.use_imm = 1'b1; end
            7'b0010011: begin wr = 1'b1; p.use_imm = 1'b1; p.alu_op = {(f3 == 3'd5) ? inst[30] : 1'b0, f3}; end
            7'b0110011: begin wr = 1'b1; p.alu_op = {inst[30], f3}; end
            default: wr = 1'b0;
        endcase
        p.illegal = (fmt == "X");
        p.reg_we = wr && (p.rd != 5'd0);
        return p;
    endfunction

    function automatic logic m_jreq(input logic fl);
        return m_valid && (m_inst[6:0] == JALO) && !m_sent && !fl;
    endfunction

    function automatic logic [31:0] m_jtgt();
        pkt_t p;
        p = ref_dec(1'b1, m_pc, m_inst);
        return m_pc + p.imm;
    endfunction

    task automatic model_edge();
        logic ejr, take, is_real;
        logic [31:0] jt;
        ejr = m_jreq(flush);
        jt = m_jtgt();
        is_real = (final_inst != NOP);
        if (rst) begin
            m_valid = 1'b0; m_sent = 1'b0; m_wait = 1'b0;
            m_pc = 32'h0; m_inst = 32'h0; m_want = 32'h0;
            exp_pkt = ref_dec(1'b0, 32'h0, 32'h0);
        end else if (flush) begin
            exp_pkt = ref_dec(1'b0, 32'h0, 32'h0);
            m_sent = 1'b0;
            take = is_real && (final_pc == b_target);
            m_wait = !take; m_want = b_target;
            if (take) begin m_pc = final_pc; m_inst = final_inst; end
            m_valid = take;
        end else if (stall) begin
            exp_pkt = ref_dec(1'b0, 32'h0, 32'h0);
            if (ejr) begin m_sent = 1'b1; m_wait = 1'b1; m_want = jt; end
        end else begin
            exp_pkt = ref_dec(m_valid, m_pc, m_inst);
            m_sent = 1'b0;
            if (ejr) begin m_wait = 1'b1; m_want = jt; end
            take = is_real && (!m_wait || final_pc == m_want);
            if (take) begin m_wait = 1'b0; m_pc = final_pc; m_inst = final_inst; end
            m_valid = take;
        end
    endtask

    // One cycle: drive, compare visible outputs with the model, advance model and clock
    task automatic run(input logic [31:0] pc, input logic [31:0] inst, input logic st,
                       input logic fl, input logic [31:0] bt, input logic r);
        logic ejr;
        final_pc = pc; final_inst = inst; stall = st; flush = fl; b_target = bt; rst = r;
        #1;
        if (chk_en) begin
            ejr = m_jreq(fl);
            check("cyc_pkt", obs, exp_pkt);
            check("cyc_jreq", jal_req, ejr);
            if (ejr) check("cyc_jtgt", jal_target, m_jtgt());
            if (jal_req === 1'b1) jal_pulses++;
        end
        model_edge();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b1111111};
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    initial begin
        logic [31:0] cur_pc, pres_pc, bt, inst, jt;
        logic st, fl, jr;
        int p0;

        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_inst", id_inst, NOP);
        check("rst_valid", id_valid, 1'b0);
        check("rst_jreq", jal_req, 1'b0);
        check("rst_jtgt", jal_target, 32'h0);

        // addi x1,x0,5
        run(32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("basic_valid", id_valid, 1'b1);
        check("basic_rd", rd, 5'd1);
        check("basic_rs1", rs1, 5'd0);
        check("basic_imm", imm, 32'd5);
        check("basic_we", {reg_we, use_imm, alu_op}, {1'b1, 1'b1, 4'd0});

        // JAL at 0x10 -> 0x18; 0x14 is wrong-path
        run(32'h10, 32'h0080_00EF, 1'b0, 1'b0, 32'h0, 1'b0);
        check("jal_req", jal_req, 1'b1);
        check("jal_target", jal_target, 32'h18);
        run(32'h14, 32'h0020_0113, 1'b0, 1'b0, 32'h0, 1'b0);
        check("jal_once", jal_req, 1'b0);
        run(32'h18, 32'h0030_0193, 1'b0, 1'b0, 32'h0, 1'b0);
        check("jal_drop14", id_valid, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("jal_take18", {id_valid, id_pc}, {1'b1, 32'h18});

        // JAL held under a 3-cycle stall
        run(32'h30, 32'h0080_00EF, 1'b0, 1'b0, 32'h0, 1'b0);
        p0 = jal_pulses;
        for (int i = 0; i < 3; i++) begin
            run(32'h34, 32'h0020_0113, 1'b1, 1'b0, 32'h0, 1'b0);
            check("stall_bubble", id_valid, 1'b0);
        end
        run(32'h34, 32'h0020_0113, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_jal_out", {id_valid, id_inst}, {1'b1, 32'h0080_00EF});
        check("stall_pulses", jal_pulses - p0, 1);
        run(32'h38, 32'h0030_0193, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_drop34", id_valid, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_take38", id_pc, 32'h38);

        // Flush to 0x44 while 0x20 sits in IF/ID
        run(32'h20, 32'h0010_0293, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h24, 32'h0020_0113, 1'b0, 1'b1, 32'h44, 1'b0);
        check("flush_idex", id_valid, 1'b0);
        run(32'h44, 32'h0020_0313, 1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_ifid", id_valid, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_take44", {id_valid, id_pc}, {1'b1, 32'h44});

        // Illegal opcode then sw x1,-4(x2)
        run(32'h50, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h54, 32'hFE11_2E23, 1'b0, 1'b0, 32'h0, 1'b0);
        check("illegal", {id_valid, illegal, reg_we}, {1'b1, 1'b1, 1'b0});
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("store", {imm, mem_we, reg_we}, {32'hFFFF_FFFC, 1'b1, 1'b0});

        // JAL to the very next PC: match arrives in the pulse cycle
        run(32'h70, 32'h0040_00EF, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h74, 32'h0010_0413, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h78, 32'h0020_0413, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("next_pc_78", {id_valid, id_pc}, {1'b1, 32'h78});

        // Reset while waiting for 0x68
        run(32'h60, 32'h0080_00EF, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h64, 32'h0020_0113, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rstr_pkt", obs, ref_dec(1'b0, 32'h0, 32'h0));
        check("rstr_jal", {jal_req, jal_target}, 33'h0);
        run(32'h8, 32'h0030_0393, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rstr_take8", {id_valid, id_pc}, {1'b1, 32'h8});

        // Randomized traffic with stalls, flushes and JAL redirects
        cur_pc = 32'h100;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 11) == 0);
            bt = 32'($urandom_range(0, 1023)) << 2;
            pres_pc = (fl && $urandom_range(0, 1) == 1) ? bt : cur_pc;
            inst = ($urandom_range(0, 7) == 0) ? NOP : rand_inst();
            jr = m_jreq(fl);
            jt = m_jtgt();
            run(pres_pc, inst, st, fl, bt, 1'b0);
            if (fl) cur_pc = (pres_pc == bt) ? bt + 32'd4 : bt;
            else if (jr) cur_pc = jt;
            else if (!st) cur_pc = cur_pc + 32'd4;
        end
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        run(32'h0, NOP, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage between `fetch` and execute. It captures each instruction that `fetch` presents on `final_pc`/`final_inst` into an IF/ID register, decodes it into RV32I register indices, an immediate and control bits, and registers the result into an ID/EX register. It detects JAL early and raises a one-shot redirect request to the hazard unit. It also filters out wrong-path instructions still in flight from `fetch` after any redirect.

## Interface
- `NOP`, default `32'h00000013`: bubble encoding. `fetch` drives this value when it has no valid instruction.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `final_pc`  in  32  PC of the presented instruction.
- `final_inst`  in  32  instruction from `fetch`; `NOP` means no instruction. Each real instruction is presented for exactly one cycle.
- `stall`  in  1  hazard-unit load-use stall: hold IF/ID and inject a bubble into ID/EX.
- `flush`  in  1  taken branch or JALR resolved in EX.
- `b_target`  in  32  redirect PC accompanying `flush`.
- `jal_req`  out  1  one-cycle pulse to the hazard unit (which drives fetch `jal`).
- `jal_target`  out  32  `if_pc + imm_j`. Valid only while `jal_req` is high.
- `id_valid`  out  1  ID/EX holds a real instruction.
- `id_pc`, `id_inst`  out  32  PC and raw instruction in ID/EX.
- `rs1`, `rs2`, `rd`  out  5  register indices. Forced to 0 when unused by the format.
- `imm`  out  32  sign-extended immediate selected by format (I/S/B/U/J). 0 for R-type.
- `alu_op`  out  4  encoding:
  - R-type: `{funct7[5], funct3}`.
  - OP-IMM: `{funct7[5] & (funct3==3'b101), funct3}`.
  - All other opcodes: `4'b0000`.
- `reg_we`, `mem_re`, `mem_we`, `is_branch`, `is_jal`, `is_jalr`, `use_imm`, `is_lui`, `is_auipc`, `illegal`  out  1 each  control bits.

## Operation
- **Input capture.** A real instruction is any `final_inst != NOP`. An accepted instruction is written into IF/ID as `if_pc`, `if_inst`, `if_valid=1`. Otherwise `if_valid=0`.
- **Filter FSM states:**
  - `NORMAL`: accept every real instruction.
  - `REDIRECT`: drop real instructions whose `final_pc != exp_pc`. The first real instruction with `final_pc == exp_pc` is accepted and the FSM returns to `NORMAL`.
- **Transitions:**
  - `flush` → `REDIRECT`, `exp_pc = b_target`. This applies from either state.
  - `jal_req` issued → `REDIRECT`, `exp_pc = jal_target`.
- **JAL detection.** Comb: `jal_req = if_valid & (if_inst[6:0]==7'b1101111) & !jal_sent & !flush`.
  - `jal_sent` is set when `jal_req` fires.
  - `jal_sent` is cleared whenever IF/ID loads a new entry or is cleared.
  - This guarantees exactly one pulse per JAL, even while held under `stall`.
- **Priority per cycle:** `rst` > `flush` > `stall` > normal advance.
  - `flush`: clear IF/ID and ID/EX to bubble. Any `jal_req` is suppressed. Any same-cycle input is dropped unless `final_pc == b_target`.
  - `stall`: IF/ID holds and input is ignored (`fetch` is stalled by the same signal). ID/EX loads a bubble.
  - Normal: ID/EX ← decode(IF/ID). IF/ID ← filtered input.
- **Bubble in ID/EX:** `id_valid=0`, `id_inst=NOP`, `id_pc=0`, all control bits, indices and `imm` = 0.
- **Decoded opcodes:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM and SYSTEM. MISC-MEM and SYSTEM decode as valid with all control bits 0.
- **Illegal opcodes.** Any other opcode sets `illegal=1` and `id_valid=1`, and clears all other control bits.
- **Register-write gating.** `reg_we` is forced to 0 when `rd==0`.
- **Immediate arithmetic.** Immediates are built from instruction bits only. Target: `jal_target = if_pc + imm_j` mod 2^32, with wrap-around allowed.

## Timing
- **Reset.** On `rst`, all outputs are 0 except `id_inst=NOP`. Also FSM=`NORMAL`, `if_valid=0`, `jal_sent=0`.
  - Reset mid-`REDIRECT` discards `exp_pc`.
- **Pipeline latency.** An instruction presented in cycle N is latched into IF/ID at edge N and appears on ID/EX outputs after edge N+1 (2-cycle latency). Each added `stall` cycle adds one cycle.
- **JAL pulse timing.** `jal_req` is high in cycle N+1, combinational from IF/ID. The instruction in cycle N+1 that sets `jal_req` is never dropped: the JAL itself proceeds to ID/EX normally.
- **Back-to-back input.** Back-to-back real instructions sustain one per cycle.
- **Redirect mid-stall.** A `flush` arriving during `stall` takes effect immediately.
- **Redirect to the next PC.** If a redirect target equals a PC already accepted, no match is re-awaited. The FSM leaves `REDIRECT` only on a new matching input.

## Test plan
- **Basic decode.** Reset, then `final_pc=0x0`, `final_inst=0x00500093` (addi x1,x0,5) for 1 cycle → 2 edges later `id_valid=1`, `rd=1`, `rs1=0`, `imm=5`, `reg_we=1`, `use_imm=1`, `alu_op=0`.
- **JAL redirect.** JAL `0x008000EF` at pc `0x10` → `jal_req` for exactly 1 cycle with `jal_target=0x18`. Then pc `0x14` is dropped (no `id_valid`) and pc `0x18` is accepted.
- **Stall hold.** `stall` for 3 cycles with JAL in IF/ID → `id_valid=0` for 3 cycles and `jal_req` pulses only once. The JAL reaches ID/EX on the cycle after `stall` drops.
- **Flush.** `flush` with `b_target=0x44` while pc `0x20` is in IF/ID → both registers become bubbles next cycle. Pc `0x24` is dropped and pc `0x44` is accepted.
- **Illegal opcode and S-type.** `0xFFFFFFFF` → `id_valid=1`, `illegal=1`, `reg_we=0`. Store `0xFE112E23` (sw x1,-4(x2)) → `imm=0xFFFFFFFC`, `mem_we=1`, `reg_we=0`.
- **Reset mid-redirect.** `rst` during `REDIRECT` → next cycle all outputs are at reset values and pc `0x8` is accepted normally.
